// File: rtl/la_dump_ctrl_if.sv
// Capture-RAM read port and UART transmitter handshake for la_dump_ctrl.
//   mem_rd_en  read strobe into the capture RAM
//   mem_addr   capture RAM read address
//   mem_rdata  RAM data, valid the cycle after mem_rd_en (registered RAM)
//   tx_data    byte handed to the UART transmitter
//   tx_start   one-cycle start pulse to the transmitter
//   tx_done    one-cycle pulse from the transmitter when the stop bit ends
// master = dump controller, slave = RAM/UART side.
interface la_dump_ctrl_if #(
    parameter int ADDR_W = 10
);
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata;
    logic [7:0]        tx_data;
    logic              tx_start;
    logic              tx_done;

    modport master (
        output mem_rd_en, mem_addr, tx_data, tx_start,
        input  mem_rdata, tx_done
    );

    modport slave (
        input  mem_rd_en, mem_addr, tx_data, tx_start,
        output mem_rdata, tx_done
    );
endinterface

// File: rtl/la_dump_ctrl.sv
// Dumps a circular logic-analyzer capture buffer over the byte UART as one
// packet: SYNC0 SYNC1 LEN_HI LEN_LO sample[0..len-1] CSUM.
// CSUM is the mod-256 sum of the two length bytes and all samples.
//
// Ports:
//   clk        system clock
//   resetn     asynchronous reset, active-low
//   dump_req   start request, honoured only while idle
//   dump_base  first sample address (latched on accept)
//   dump_len   sample count, clamped to the buffer depth (latched on accept)
//   abort_req  stop after the byte currently in flight
//   busy       high from accept until done
//   done       one-cycle pulse at packet end
//   aborted    set with done when the packet ended by abort
//   bus        RAM read port + UART handshake (master side)
//
// state       | meaning
// ------------+------------------------------------------------
// S_IDLE      | waiting for dump_req
// S_HDR       | load sync/length/checksum byte into tx_data
// S_FETCH     | RAM read strobe asserted for one cycle
// S_FETCH_WAIT| capture RAM data into tx_data and checksum
// S_TX_START  | tx_start pulse
// S_TX_WAIT   | byte in flight, waiting for tx_done
// S_NEXT      | choose header, sample, checksum or end
module la_dump_ctrl #(
    parameter int         ADDR_W = 10,
    parameter logic [7:0] SYNC0  = 8'hA5,
    parameter logic [7:0] SYNC1  = 8'h5A
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              dump_req,
    input  logic [ADDR_W-1:0] dump_base,
    input  logic [ADDR_W:0]   dump_len,
    input  logic              abort_req,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    la_dump_ctrl_if.master    bus
);
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_FETCH,
        S_FETCH_WAIT,
        S_TX_START,
        S_TX_WAIT,
        S_NEXT
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   idx_q;
    // 0..3 select SYNC0/SYNC1/LEN_HI/LEN_LO, 4 selects CSUM, 5 = CSUM sent
    logic [2:0]        hdr_sel;
    logic [7:0]        csum;
    logic              abort_pend;
    logic [15:0]       len16;

    assign len16 = 16'(len_q);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= S_IDLE;
            base_q       <= '0;
            len_q        <= '0;
            idx_q        <= '0;
            hdr_sel      <= '0;
            csum         <= '0;
            abort_pend   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            aborted      <= 1'b0;
            bus.mem_rd_en <= 1'b0;
            bus.mem_addr  <= '0;
            bus.tx_data   <= '0;
            bus.tx_start  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (busy && abort_req) begin
                abort_pend <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (dump_req) begin
                        base_q     <= dump_base;
                        len_q      <= (dump_len > DEPTH) ? DEPTH : dump_len;
                        idx_q      <= '0;
                        hdr_sel    <= '0;
                        csum       <= '0;
                        abort_pend <= 1'b0;
                        aborted    <= 1'b0;
                        busy       <= 1'b1;
                        state      <= S_HDR;
                    end
                end

                S_HDR: begin
                    case (hdr_sel)
                        3'd0: bus.tx_data <= SYNC0;
                        3'd1: bus.tx_data <= SYNC1;
                        3'd2: begin
                            bus.tx_data <= len16[15:8];
                            csum        <= csum + len16[15:8];
                        end
                        3'd3: begin
                            bus.tx_data <= len16[7:0];
                            csum        <= csum + len16[7:0];
                        end
                        default: bus.tx_data <= csum;
                    endcase
                    hdr_sel      <= hdr_sel + 3'd1;
                    bus.tx_start <= 1'b1;
                    state        <= S_TX_START;
                end

                S_FETCH: begin
                    bus.mem_rd_en <= 1'b0;
                    state         <= S_FETCH_WAIT;
                end

                S_FETCH_WAIT: begin
                    bus.tx_data  <= bus.mem_rdata;
                    csum         <= csum + bus.mem_rdata;
                    bus.tx_start <= 1'b1;
                    state        <= S_TX_START;
                end

                S_TX_START: begin
                    bus.tx_start <= 1'b0;
                    state        <= S_TX_WAIT;
                end

                S_TX_WAIT: begin
                    if (bus.tx_done) begin
                        state <= S_NEXT;
                    end
                end

                S_NEXT: begin
                    // abort_req is also looked at directly so a request on
                    // this very cycle is not lost behind the sticky register
                    if (abort_pend || abort_req) begin
                        done    <= 1'b1;
                        aborted <= 1'b1;
                        busy    <= 1'b0;
                        state   <= S_IDLE;
                    end else if (hdr_sel == 3'd5) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else if (hdr_sel < 3'd4) begin
                        state <= S_HDR;
                    end else if (idx_q < len_q) begin
                        // address wraps naturally at the ADDR_W boundary
                        bus.mem_rd_en <= 1'b1;
                        bus.mem_addr  <= base_q + idx_q[ADDR_W-1:0];
                        idx_q         <= idx_q + 1'b1;
                        state         <= S_FETCH;
                    end else begin
                        state <= S_HDR;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_la_dump_ctrl.sv
module tb_la_dump_ctrl;
    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          dump_req = 1'b0;
    logic          abort_req = 1'b0;
    logic [AW-1:0] dump_base = '0;
    logic [AW:0]   dump_len = '0;
    logic          busy;
    logic          done;
    logic          aborted;

    la_dump_ctrl_if #(.ADDR_W(AW)) bus ();

    la_dump_ctrl #(.ADDR_W(AW)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .dump_req  (dump_req),
        .dump_base (dump_base),
        .dump_len  (dump_len),
        .abort_req (abort_req),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // registered capture RAM
    logic [7:0] ram [DEPTH];
    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rdata <= ram[bus.mem_addr];
    end

    // reference state shared between stimulus and the compare process
    logic [7:0]    exp_bytes[$];
    logic [AW-1:0] exp_addr[$];
    int checks = 0;
    int errors = 0;
    int bytes_sent = 0;
    int done_seen = 0;
    int rd_count = 0;
    int cur_len = 0;
    bit exp_aborted = 1'b0;
    int dly_min = 20;
    int dly_max = 20;
    bit spurious_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out", name);
    endtask

    // Expected frame straight from the packet definition.
    task automatic build(input int base, input int len);
        int s;
        int l;
        logic [AW-1:0] a;
        l = (len > DEPTH) ? DEPTH : len;
        exp_bytes.delete();
        exp_addr.delete();
        exp_bytes.push_back(8'hA5);
        exp_bytes.push_back(8'h5A);
        exp_bytes.push_back(8'(l / 256));
        exp_bytes.push_back(8'(l % 256));
        s = l / 256 + l % 256;
        for (int i = 0; i < l; i++) begin
            a = AW'((base + i) % DEPTH);
            exp_addr.push_back(a);
            exp_bytes.push_back(ram[a]);
            s += int'(ram[a]);
        end
        exp_bytes.push_back(8'(s % 256));
        cur_len = l;
    endtask

    // Compare process: UART model, RAM-read checks, done checks.
    initial begin
        bit         in_flight;
        logic [7:0] held;
        int         cd;
        int         gap;
        int         k;
        bit         prev_rd;
        bit         prev_done;
        in_flight = 0; held = '0; cd = 0; gap = 0; prev_rd = 0; prev_done = 0;
        bus.tx_done = 1'b0;
        forever begin
            @(negedge clk);
            bus.tx_done = 1'b0;
            gap++;
            if (!resetn) begin
                in_flight = 0;
                prev_rd = 0;
                prev_done = 0;
                continue;
            end
            if (bus.tx_start) begin
                if (in_flight) chk("tx_start_overlap", 32'(bus.tx_start), 0);
                if (exp_bytes.size() == 0) begin
                    chk("tx_extra", 32'(bus.tx_start), 0);
                end else begin
                    k = bytes_sent;
                    chk($sformatf("byte%0d", k), 32'(bus.tx_data), 32'(exp_bytes.pop_front()));
                    if (k >= 4 && k < 4 + cur_len) chk("gap_sample", gap, 4);
                    else if (k > 0) chk("gap_hdr", gap, 3);
                end
                bytes_sent++;
                in_flight = 1;
                held = bus.tx_data;
                cd = int'($urandom_range(dly_max, dly_min));
            end else if (in_flight) begin
                chk("tx_data_hold", 32'(bus.tx_data), 32'(held));
                cd--;
                if (cd <= 0) begin
                    bus.tx_done = 1'b1;
                    in_flight = 0;
                    gap = 0;
                end
            end else if (spurious_en && $urandom_range(7, 0) == 0) begin
                bus.tx_done = 1'b1;
            end

            if (bus.mem_rd_en) begin
                rd_count++;
                chk("rd_en_single", 32'(prev_rd), 0);
                if (exp_addr.size() == 0) chk("rd_extra", 32'(bus.mem_rd_en), 0);
                else chk("mem_addr", 32'(bus.mem_addr), 32'(exp_addr.pop_front()));
            end
            prev_rd = bus.mem_rd_en;

            if (done) begin
                chk("done_busy", 32'(busy), 0);
                chk("done_single", 32'(prev_done), 0);
                chk("aborted", 32'(aborted), 32'(exp_aborted));
                chk("bytes_left", exp_bytes.size(), 0);
                chk("addr_left", exp_addr.size(), 0);
                done_seen++;
            end
            prev_done = done;
        end
    end

    task automatic wait_bytes(input int n, input int budget);
        while (bytes_sent < n && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (bytes_sent < n) timeout("wait_bytes");
    endtask

    task automatic run_dump(input int base, input int len, input int dmin, input int dmax,
                            input int abort_k, input bit abort_with_accept, input bit busy_req);
        int budget;
        int start_done;
        build(base, len);
        dly_min = dmin;
        dly_max = dmax;
        exp_aborted = 1'b0;
        bytes_sent = 0;
        start_done = done_seen;
        budget = (cur_len + 5) * (dmax + 6) + 100;
        @(negedge clk);
        dump_base = AW'(base);
        dump_len = (AW+1)'(len);
        dump_req = 1'b1;
        abort_req = abort_with_accept;
        @(negedge clk);
        dump_req = 1'b0;
        abort_req = 1'b0;
        dump_base = AW'($urandom);
        dump_len = (AW+1)'($urandom);
        chk("busy_after_accept", 32'(busy), 1);
        chk("tx_start_early", 32'(bus.tx_start), 0);
        @(negedge clk);
        chk("sync0_latency", 32'(bus.tx_start), 1);
        if (busy_req) begin
            repeat (5) @(negedge clk);
            dump_req = 1'b1;
            @(negedge clk);
            dump_req = 1'b0;
        end
        if (abort_k >= 0) begin
            wait_bytes(abort_k + 1, budget);
            @(negedge clk);
            abort_req = 1'b1;
            exp_aborted = 1'b1;
            exp_bytes.delete();
            exp_addr.delete();
            @(negedge clk);
            abort_req = 1'b0;
        end
        while (done_seen == start_done && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (done_seen == start_done) timeout("done_wait");
        repeat (3) @(negedge clk);
        chk("idle_busy", 32'(busy), 0);
        chk("done_count", done_seen - start_done, 1);
    endtask

    initial begin
        logic [7:0]    lit_a[8];
        logic [7:0]    lit_z[5];
        logic [AW-1:0] lit_addr[4];
        int            len;
        int            start;
        lit_a = '{8'hA5, 8'h5A, 8'h00, 8'h03, 8'h01, 8'h02, 8'hFF, 8'h05};
        lit_z = '{8'hA5, 8'h5A, 8'h00, 8'h00, 8'h00};
        lit_addr = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
        for (int i = 0; i < DEPTH; i++) ram[i] = 8'($urandom);

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_aborted", 32'(aborted), 0);
        chk("rst_tx_start", 32'(bus.tx_start), 0);
        chk("rst_rd_en", 32'(bus.mem_rd_en), 0);
        chk("rst_tx_data", 32'(bus.tx_data), 0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 0);
        resetn = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("idle_busy", 32'(busy), 0);
            chk("idle_tx_start", 32'(bus.tx_start), 0);
            chk("idle_rd_en", 32'(bus.mem_rd_en), 0);
        end

        // three samples, hand-computed frame
        ram[0] = 8'h01; ram[1] = 8'h02; ram[2] = 8'hFF;
        build(0, 3);
        chk("model_a_size", exp_bytes.size(), 8);
        for (int i = 0; i < 8; i++) chk("model_a_byte", 32'(exp_bytes[i]), 32'(lit_a[i]));
        run_dump(0, 3, 20, 20, -1, 0, 0);
        chk("a_bytes_sent", bytes_sent, 8);

        // address wrap
        build(10'h3FE, 4);
        for (int i = 0; i < 4; i++) chk("model_wrap_addr", 32'(exp_addr[i]), 32'(lit_addr[i]));
        chk("model_wrap_lenhi", 32'(exp_bytes[2]), 32'h00);
        chk("model_wrap_lenlo", 32'(exp_bytes[3]), 32'h04);
        run_dump(10'h3FE, 4, 5, 12, -1, 0, 0);

        // empty dump
        build(100, 0);
        chk("model_z_size", exp_bytes.size(), 5);
        for (int i = 0; i < 5; i++) chk("model_z_byte", 32'(exp_bytes[i]), 32'(lit_z[i]));
        rd_count = 0;
        run_dump(100, 0, 20, 20, -1, 0, 0);
        chk("z_reads", rd_count, 0);

        // oversize length clamps to the buffer depth
        build(7, 11'h7FF);
        chk("model_clamp_size", exp_bytes.size(), 1029);
        chk("model_clamp_lenhi", 32'(exp_bytes[2]), 32'h04);
        chk("model_clamp_lenlo", 32'(exp_bytes[3]), 32'h00);
        rd_count = 0;
        run_dump(7, 11'h7FF, 1, 3, -1, 0, 0);
        chk("clamp_reads", rd_count, 1024);

        // abort while sample[1] is in flight, dump_req while busy ignored
        run_dump(200, 5, 20, 20, 5, 0, 1);
        chk("abort_bytes_sent", bytes_sent, 6);
        run_dump(200, 5, 20, 20, -1, 0, 0);
        chk("after_abort_bytes", bytes_sent, 10);

        // abort coincident with accept is ignored
        run_dump(int'($urandom_range(DEPTH - 1, 0)), 6, 3, 10, -1, 1, 0);

        // randomized dumps with spurious tx_done outside byte flight
        spurious_en = 1'b1;
        for (int n = 0; n < 20; n++) begin
            len = int'($urandom_range(40, 0));
            run_dump(int'($urandom_range(DEPTH - 1, 0)), len, 3, int'($urandom_range(15, 3)),
                     ($urandom_range(2, 0) == 0) ? int'($urandom_range(len + 4, 0)) : -1,
                     1'($urandom_range(1, 0)), 0);
        end
        spurious_en = 1'b0;

        // reset mid-dump: immediate stop, no done
        build(37, 10);
        dly_min = 5; dly_max = 8; bytes_sent = 0; exp_aborted = 1'b0;
        start = done_seen;
        @(negedge clk);
        dump_base = AW'(37); dump_len = (AW+1)'(10); dump_req = 1'b1;
        @(negedge clk);
        dump_req = 1'b0;
        wait_bytes(6, 200);
        @(negedge clk);
        resetn = 1'b0;
        exp_bytes.delete();
        exp_addr.delete();
        @(negedge clk);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_tx_start", 32'(bus.tx_start), 0);
        chk("midrst_rd_en", 32'(bus.mem_rd_en), 0);
        chk("midrst_done", 32'(done), 0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (5) @(negedge clk);
        chk("midrst_no_done", done_seen - start, 0);
        chk("midrst_idle", 32'(busy), 0);
        run_dump(500, 8, 3, 9, -1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
